mlp_param_loader: RTL and testbench

MLP_PARAM_LOADER -- requirements
Module: mlp_param_loader

---
 rtl/mlp_param_loader.sv | 166 ++++++++++++++++
 tb/tb_mlp_param_loader.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mlp_param_loader.sv
// Streams an input vector, weights and biases into registered MLP parameter
// banks, then fires a one-cycle control pulse so the MLP can start computing.
module mlp_param_loader #(
  parameter int M  = 3,
  parameter int N  = 3,
  parameter int QM = 3,
  parameter int QN = 5,
  localparam int DW = QM + QN
) (
  input  logic                                 clk,
  input  logic                                 nrst,
  input  logic                                 start,
  input  logic                                 x_only,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic signed [DW-1:0]                 in_data,
  output logic [N-1:0][DW-1:0]                 x,
  output logic [M-2:0][N-1:0][N-1:0][DW-1:0]   w,
  output logic [M-2:0][N-1:0][DW-1:0]          b,
  output logic                                 init,
  output logic                                 initial_flag,
  output logic                                 weight_flag,
  output logic                                 busy,
  output logic                                 done
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int LW = (M > 2) ? $clog2(M - 1) : 1;
  localparam logic [CW-1:0] LAST_N = CW'(N - 1);
  localparam logic [LW-1:0] LAST_L = LW'(M - 2);

  typedef enum logic [2:0] {
    IDLE,
    LOAD_X,
    LOAD_W,
    LOAD_B,
    FIRE
  } state_t;

  state_t         state;
  logic [CW-1:0]  cnt_k;
  logic [CW-1:0]  cnt_j;
  logic [LW-1:0]  cnt_l;
  logic           reload_x_only;

  logic accept;
  logic last_x;
  logic last_w;
  logic last_b;
  logic go_fire;

  assign accept  = in_valid & in_ready;
  assign last_x  = (state == LOAD_X) && (cnt_k == LAST_N);
  assign last_w  = (state == LOAD_W) && (cnt_k == LAST_N) && (cnt_j == LAST_N) && (cnt_l == LAST_L);
  assign last_b  = (state == LOAD_B) && (cnt_j == LAST_N) && (cnt_l == LAST_L);
  assign go_fire = accept & ((last_x & reload_x_only) | last_b);

  // NOTE: state, counters and outputs are all sequential, so every assignment
  // in this block is non-blocking; the combinational decode above is read-only here.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state         <= IDLE;
      cnt_k         <= '0;
      cnt_j         <= '0;
      cnt_l         <= '0;
      reload_x_only <= 1'b0;
      in_ready      <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      init          <= 1'b0;
      initial_flag  <= 1'b0;
      weight_flag   <= 1'b0;
      // NOTE: the parameter banks are flops, not RAM, so they can and do take
      // the async reset; the MLP must never see stale weights after a reset.
      x             <= '0;
      w             <= '0;
      b             <= '0;
    end else begin
      done         <= go_fire;
      init         <= go_fire;
      initial_flag <= go_fire;
      weight_flag  <= go_fire & ~reload_x_only;

      case (state)
        IDLE: begin
          if (start) begin
            reload_x_only <= x_only;
            cnt_k         <= '0;
            cnt_j         <= '0;
            cnt_l         <= '0;
            state         <= LOAD_X;
            in_ready      <= 1'b1;
            busy          <= 1'b1;
          end
        end

        LOAD_X: begin
          if (accept) begin
            x[cnt_k] <= in_data;
            if (cnt_k == LAST_N) begin
              cnt_k <= '0;
              if (reload_x_only) begin
                state    <= FIRE;
                in_ready <= 1'b0;
              end else begin
                state <= LOAD_W;
              end
            end else begin
              cnt_k <= cnt_k + CW'(1);
            end
          end
        end

        LOAD_W: begin
          if (accept) begin
            w[cnt_l][cnt_j][cnt_k] <= in_data;
            if (last_w) begin
              cnt_k <= '0;
              cnt_j <= '0;
              cnt_l <= '0;
              state <= LOAD_B;
            end else if (cnt_k != LAST_N) begin
              cnt_k <= cnt_k + CW'(1);
            end else if (cnt_j != LAST_N) begin
              cnt_k <= '0;
              cnt_j <= cnt_j + CW'(1);
            end else begin
              cnt_k <= '0;
              cnt_j <= '0;
              cnt_l <= cnt_l + LW'(1);
            end
          end
        end

        LOAD_B: begin
          if (accept) begin
            b[cnt_l][cnt_j] <= in_data;
            if (last_b) begin
              cnt_j    <= '0;
              cnt_l    <= '0;
              state    <= FIRE;
              in_ready <= 1'b0;
            end else if (cnt_j != LAST_N) begin
              cnt_j <= cnt_j + CW'(1);
            end else begin
              cnt_j <= '0;
              cnt_l <= cnt_l + LW'(1);
            end
          end
        end

        FIRE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end

        default: begin
          state    <= IDLE;
          in_ready <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mlp_param_loader.sv
// Directed bench for mlp_param_loader with the default 3-layer, 3-neuron,
// Q3.5 configuration; expected bank contents come from a small ordering model.
module tb_mlp_param_loader;

  localparam int M     = 3;
  localparam int N     = 3;
  localparam int DW    = 8;
  localparam int TOTAL = N + (M - 1) * N * N + (M - 1) * N;

  logic                               clk;
  logic                               nrst;
  logic                               start;
  logic                               x_only;
  logic                               in_valid;
  logic                               in_ready;
  logic signed [DW-1:0]               in_data;
  logic [N-1:0][DW-1:0]               x;
  logic [M-2:0][N-1:0][N-1:0][DW-1:0] w;
  logic [M-2:0][N-1:0][DW-1:0]        b;
  logic                               init;
  logic                               initial_flag;
  logic                               weight_flag;
  logic                               busy;
  logic                               done;

  mlp_param_loader #(.M(M), .N(N), .QM(3), .QN(5)) dut (
    .clk          (clk),
    .nrst         (nrst),
    .start        (start),
    .x_only       (x_only),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .x            (x),
    .w            (w),
    .b            (b),
    .init         (init),
    .initial_flag (initial_flag),
    .weight_flag  (weight_flag),
    .busy         (busy),
    .done         (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_compared = 0;
  int n_failed   = 0;

  logic [DW-1:0] exp_x [N];
  logic [DW-1:0] exp_w [M-1][N][N];
  logic [DW-1:0] exp_b [M-1][N];
  logic [DW-1:0] words [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expected);
    n_compared++;
    if (got !== expected) begin
      n_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, expected);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < N; i++) exp_x[i] = '0;
    for (int l = 0; l < M - 1; l++)
      for (int j = 0; j < N; j++) begin
        exp_b[l][j] = '0;
        for (int k = 0; k < N; k++) exp_w[l][j][k] = '0;
      end
  endtask

  // Stream order: x[0..N-1], then w[l][j][k] with k fastest, then b[l][j].
  task automatic model_write(input int idx, input logic [DW-1:0] d);
    int t;
    if (idx < N) begin
      exp_x[idx] = d;
    end else if (idx < N + (M - 1) * N * N) begin
      t = idx - N;
      exp_w[t / (N * N)][(t / N) % N][t % N] = d;
    end else begin
      t = idx - N - (M - 1) * N * N;
      exp_b[t / N][t % N] = d;
    end
  endtask

  task automatic compare_all(input string tag);
    for (int i = 0; i < N; i++)
      check($sformatf("%s x[%0d]", tag, i), x[i], exp_x[i]);
    for (int l = 0; l < M - 1; l++)
      for (int j = 0; j < N; j++) begin
        check($sformatf("%s b[%0d][%0d]", tag, l, j), b[l][j], exp_b[l][j]);
        for (int k = 0; k < N; k++)
          check($sformatf("%s w[%0d][%0d][%0d]", tag, l, j, k), w[l][j][k], exp_w[l][j][k]);
      end
  endtask

  // Runs one sequence from the words queue. Cycle 1 is the cycle after the
  // start edge; fire_cycle is the cycle in which done is seen high.
  task automatic load_seq(input string tag, input bit xo, input bit toggle,
                          input bit hold_start, output int fire_cycle);
    int  idx;
    int  cyc;
    int  ready_bad;
    bit  phase;
    int  nwords;
    idx        = 0;
    ready_bad  = 0;
    phase      = 1'b1;
    fire_cycle = -1;
    nwords     = xo ? N : TOTAL;
    @(negedge clk);
    start  = 1'b1;
    x_only = xo;
    @(posedge clk);
    @(negedge clk);
    if (!hold_start) start = 1'b0;
    cyc = 1;
    while (cyc < 200 && fire_cycle < 0) begin
      if (done === 1'b1) begin
        fire_cycle = cyc;
      end else begin
        if (in_ready !== 1'b1) ready_bad++;
        if (idx < nwords) begin
          in_valid = toggle ? phase : 1'b1;
          in_data  = in_valid ? words[idx] : 8'hEE;
          if (in_valid && in_ready) begin
            model_write(idx, words[idx]);
            idx++;
          end
        end else begin
          in_valid = 1'b0;
        end
        phase = ~phase;
        @(negedge clk);
        cyc++;
      end
    end
    check({tag, " fire cycle"}, fire_cycle, xo ? (toggle ? 2 * N : N + 1)
                                               : (toggle ? 2 * TOTAL : TOTAL + 1));
    check({tag, " in_ready during load"}, ready_bad, 0);
    check({tag, " init in FIRE"}, init, 1'b1);
    check({tag, " initial_flag in FIRE"}, initial_flag, 1'b1);
    check({tag, " weight_flag in FIRE"}, weight_flag, !xo);
    check({tag, " in_ready in FIRE"}, in_ready, 1'b0);
    check({tag, " busy in FIRE"}, busy, 1'b1);
    in_valid = 1'b0;
    @(negedge clk);
    check({tag, " pulses low after FIRE"}, {done, init, initial_flag, weight_flag}, 4'b0000);
    check({tag, " busy low after FIRE"}, busy, 1'b0);
  endtask

  int fc;
  int seen_done;
  int seen_ready;

  initial begin
    nrst     = 1'b0;
    start    = 1'b0;
    x_only   = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    clear_model();
    repeat (2) @(negedge clk);
    check("reset in_ready", in_ready, 1'b0);
    check("reset busy", busy, 1'b0);
    check("reset pulses", {done, init, initial_flag, weight_flag}, 4'b0000);
    compare_all("reset");
    nrst = 1'b1;

    // Uniform full load with in_valid held high.
    words.delete();
    for (int i = 0; i < TOTAL; i++) words.push_back(8'h10);
    load_seq("uniform", 1'b0, 1'b0, 1'b0, fc);
    compare_all("uniform");
    check("uniform w[1][2][2]", w[1][2][2], 8'h10);

    // Ramp full load: each word equals its stream position.
    words.delete();
    for (int i = 0; i < TOTAL; i++) words.push_back(8'(i));
    load_seq("ramp", 1'b0, 1'b0, 1'b0, fc);
    check("ramp x[0]", x[0], 8'h00);
    check("ramp x[2]", x[2], 8'h02);
    check("ramp w[0][0][0]", w[0][0][0], 8'h03);
    check("ramp w[0][1][2]", w[0][1][2], 8'h08);
    check("ramp w[1][2][2]", w[1][2][2], 8'h14);
    check("ramp b[0][0]", b[0][0], 8'h15);
    check("ramp b[1][2]", b[1][2], 8'h1A);
    compare_all("ramp");

    // Input-only reload must leave the weight and bias banks untouched.
    words.delete();
    words.push_back(8'hF0);
    words.push_back(8'h08);
    words.push_back(8'h7F);
    load_seq("xonly", 1'b1, 1'b0, 1'b0, fc);
    check("xonly x[0]", x[0], 8'hF0);
    check("xonly x[1]", x[1], 8'h08);
    check("xonly x[2]", x[2], 8'h7F);
    check("xonly w[1][2][2] kept", w[1][2][2], 8'h14);
    check("xonly b[0][0] kept", b[0][0], 8'h15);
    compare_all("xonly");

    // Alternating valid: garbage on invalid cycles must not be stored.
    words.delete();
    for (int i = 0; i < TOTAL; i++) words.push_back(8'h10);
    load_seq("toggle", 1'b0, 1'b1, 1'b0, fc);
    compare_all("toggle");

    // Abort after ten accepted words.
    @(negedge clk);
    start  = 1'b1;
    x_only = 1'b0;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(8'h30 + i);
      @(negedge clk);
    end
    check("abort x[0] before reset", x[0], 8'h30);
    nrst = 1'b0;
    #1;
    clear_model();
    check("abort in_ready", in_ready, 1'b0);
    check("abort busy", busy, 1'b0);
    check("abort pulses", {done, init, initial_flag, weight_flag}, 4'b0000);
    compare_all("abort");
    @(negedge clk);
    nrst       = 1'b1;
    seen_done  = 0;
    seen_ready = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done !== 1'b0) seen_done++;
      if (in_ready !== 1'b0) seen_ready++;
    end
    in_valid = 1'b0;
    check("abort no FIRE", seen_done, 0);
    check("abort in_ready idle", seen_ready, 0);
    compare_all("abort idle");

    // start held high across the whole load: one FIRE, then a restart.
    words.delete();
    for (int i = 0; i < TOTAL; i++) words.push_back(8'(8'h40 + i));
    load_seq("hold", 1'b0, 1'b0, 1'b1, fc);
    compare_all("hold");
    @(negedge clk);
    check("hold restart busy", busy, 1'b1);
    check("hold restart in_ready", in_ready, 1'b1);
    start = 1'b0;
    nrst  = 1'b0;
    @(negedge clk);
    nrst = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
    $finish;
  end

endmodule
